// File: rtl/split_head_dispatcher.sv
// split_head_dispatcher: buffers GROUP_NUM head-group slices, then emits one gathered head per handshake
module split_head_dispatcher #(
    parameter int DATA_WIDTH     = 8,
    parameter int SEQ_LEN        = 128,
    parameter int GROUP_HEADS    = 4,
    parameter int HEAD_DIM       = 64,
    parameter int HEAD_NUM       = 12,
    parameter int HEAD_IDX_WIDTH = 4
) (
    input  logic                                           clk_p,
    input  logic                                           rst_n,
    input  logic [DATA_WIDTH*SEQ_LEN*GROUP_HEADS*HEAD_DIM-1:0] group_matrix,
    input  logic                                           in_valid_n,
    output logic                                           busy,
    output logic [DATA_WIDTH*SEQ_LEN*HEAD_DIM-1:0]          head_matrix,
    output logic [HEAD_IDX_WIDTH-1:0]                      head_idx,
    output logic                                           out_valid_n,
    input  logic                                           out_ready,
    output logic                                           done,
    output logic                                           overflow
);
    localparam int GROUP_NUM = HEAD_NUM / GROUP_HEADS;
    localparam int GI_W      = GROUP_NUM > 1 ? $clog2(GROUP_NUM) : 1;
    localparam int GW        = DATA_WIDTH * SEQ_LEN * GROUP_HEADS * HEAD_DIM;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t                    state_q;
    logic [GI_W-1:0]           fill_cnt_q;
    logic [HEAD_IDX_WIDTH-1:0] head_cnt_q;
    logic [GW-1:0]             buf_q [GROUP_NUM];
    logic                      busy_q, out_valid_n_q, done_q, overflow_q;
    logic [GI_W-1:0]           g_sel;
    logic [31:0]               h_sel;

    assign g_sel       = GI_W'(32'(head_cnt_q) / GROUP_HEADS);
    assign h_sel       = 32'(head_cnt_q) % GROUP_HEADS;
    assign busy        = busy_q;
    assign out_valid_n = out_valid_n_q;
    assign done        = done_q;
    assign overflow    = overflow_q;
    assign head_idx    = head_cnt_q;

    // Head h of the selected slot is strided by GROUP_HEADS*HEAD_DIM elements per sequence row
    always_comb begin
        head_matrix = '0;
        for (int s = 0; s < SEQ_LEN; s++)
            for (int d = 0; d < HEAD_DIM; d++)
                head_matrix[(s*HEAD_DIM+d)*DATA_WIDTH +: DATA_WIDTH] =
                    buf_q[g_sel][((s*GROUP_HEADS+h_sel)*HEAD_DIM+d)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fill_cnt_q    <= '0;
            head_cnt_q    <= '0;
            busy_q        <= 1'b0;
            out_valid_n_q <= 1'b1;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
            for (int i = 0; i < GROUP_NUM; i++) buf_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, FILL: begin
                    if (!in_valid_n) begin
                        buf_q[fill_cnt_q] <= group_matrix;
                        if (fill_cnt_q == GI_W'(GROUP_NUM-1)) begin
                            state_q       <= DRAIN;
                            fill_cnt_q    <= '0;
                            head_cnt_q    <= '0;
                            busy_q        <= 1'b1;
                            out_valid_n_q <= 1'b0;
                        end else begin
                            state_q    <= FILL;
                            fill_cnt_q <= fill_cnt_q + GI_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!in_valid_n) overflow_q <= 1'b1;
                    if (out_ready) begin
                        if (head_cnt_q == HEAD_IDX_WIDTH'(HEAD_NUM-1)) begin
                            state_q       <= IDLE;
                            head_cnt_q    <= '0;
                            busy_q        <= 1'b0;
                            out_valid_n_q <= 1'b1;
                            done_q        <= 1'b1;
                        end else begin
                            head_cnt_q <= head_cnt_q + HEAD_IDX_WIDTH'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_split_head_dispatcher.sv
// tb_split_head_dispatcher: directed table plus hand sequences for fill, stall, overflow and reset
module tb_split_head_dispatcher;
    logic        clk_p = 1'b0;
    logic        rst_n;
    logic [63:0] group_matrix;
    logic        in_valid_n;
    logic        busy;
    logic [31:0] head_matrix;
    logic [3:0]  head_idx;
    logic        out_valid_n;
    logic        out_ready;
    logic        done;
    logic        overflow;

    int checks = 0;
    int failures = 0;
    logic ovf = 1'b0;

    split_head_dispatcher #(
        .DATA_WIDTH(8), .SEQ_LEN(2), .GROUP_HEADS(2), .HEAD_DIM(2), .HEAD_NUM(4), .HEAD_IDX_WIDTH(4)
    ) dut (
        .clk_p(clk_p), .rst_n(rst_n), .group_matrix(group_matrix), .in_valid_n(in_valid_n),
        .busy(busy), .head_matrix(head_matrix), .head_idx(head_idx), .out_valid_n(out_valid_n),
        .out_ready(out_ready), .done(done), .overflow(overflow)
    );

    always #5 clk_p = ~clk_p;

    typedef struct {
        logic        vn;
        logic [63:0] gm;
        logic        rdy;
        logic        ovn;
        logic        bsy;
        logic [3:0]  idx;
        logic [31:0] hm;
        logic        dn;
    } vec_t;
    vec_t tbl [7];

    function automatic logic [7:0] el(input int salt, input int g, input int s, input int h, input int d);
        return 8'((g << 6) | (s << 5) | (h << 4) | (d << 3) | salt);
    endfunction

    function automatic logic [63:0] slice(input int salt, input int g);
        logic [63:0] r = '0;
        for (int s = 0; s < 2; s++)
            for (int h = 0; h < 2; h++)
                for (int d = 0; d < 2; d++)
                    r[((s*2+h)*2+d)*8 +: 8] = el(salt, g, s, h, d);
        return r;
    endfunction

    function automatic logic [31:0] head(input int salt, input int n);
        logic [31:0] r = '0;
        for (int s = 0; s < 2; s++)
            for (int d = 0; d < 2; d++)
                r[(s*2+d)*8 +: 8] = el(salt, n / 2, s, n % 2, d);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
    endtask

    task automatic chk_all(input string tag, input logic ovn, input logic bsy, input logic [3:0] idx,
                           input logic [31:0] hm, input logic dn, input logic ov);
        chk({tag, ".out_valid_n"}, 64'(out_valid_n), 64'(ovn));
        chk({tag, ".busy"}, 64'(busy), 64'(bsy));
        chk({tag, ".head_idx"}, 64'(head_idx), 64'(idx));
        chk({tag, ".head_matrix"}, 64'(head_matrix), 64'(hm));
        chk({tag, ".done"}, 64'(done), 64'(dn));
        chk({tag, ".overflow"}, 64'(overflow), 64'(ov));
    endtask

    task automatic step();
        @(posedge clk_p);
        #1;
    endtask

    task automatic load(input int salt, input int gap);
        in_valid_n   = 1'b0;
        group_matrix = slice(salt, 0);
        step();
        chk_all("load_beat0", 1'b1, 1'b0, 4'd0, head(salt, 0), 1'b0, ovf);
        in_valid_n = 1'b1;
        for (int i = 0; i < gap; i++) begin
            step();
            chk_all("load_gap", 1'b1, 1'b0, 4'd0, head(salt, 0), 1'b0, ovf);
        end
        in_valid_n   = 1'b0;
        group_matrix = slice(salt, 1);
        step();
        chk_all("load_beat1", 1'b0, 1'b1, 4'd0, head(salt, 0), 1'b0, ovf);
        in_valid_n = 1'b1;
    endtask

    task automatic drain_seq(input string tag, input logic [6:0] rp, input logic [6:0] ip,
                             input int len, input int salt);
        int cnt = 0;
        logic fin = 1'b0;
        logic edn;
        for (int i = 0; i < len; i++) begin
            out_ready    = rp[i];
            in_valid_n   = ~ip[i];
            group_matrix = {8{8'hEE}};
            step();
            edn = 1'b0;
            if (ip[i]) ovf = 1'b1;
            if (!fin && rp[i]) begin
                if (cnt == 3) begin
                    fin = 1'b1;
                    edn = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
            if (fin) chk_all(tag, 1'b1, 1'b0, 4'd0, head(salt, 0), edn, ovf);
            else chk_all(tag, 1'b0, 1'b1, 4'(cnt), head(salt, cnt), 1'b0, ovf);
        end
        in_valid_n = 1'b1;
        step();
        chk_all({tag, "_after"}, 1'b1, 1'b0, 4'd0, head(salt, 0), 1'b0, ovf);
        chk({tag, "_complete"}, 64'(fin), 64'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid_n   = 1'b1;
        out_ready    = 1'b0;
        group_matrix = '0;
        #12;
        chk_all("reset", 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk_all("post_reset", 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);

        tbl[0] = '{1'b0, slice(0, 0), 1'b1, 1'b1, 1'b0, 4'd0, head(0, 0), 1'b0};
        tbl[1] = '{1'b0, slice(0, 1), 1'b1, 1'b0, 1'b1, 4'd0, head(0, 0), 1'b0};
        tbl[2] = '{1'b1, 64'h0,       1'b1, 1'b0, 1'b1, 4'd1, 32'h3830_1810, 1'b0};
        tbl[3] = '{1'b1, 64'h0,       1'b1, 1'b0, 1'b1, 4'd2, head(0, 2), 1'b0};
        tbl[4] = '{1'b1, 64'h0,       1'b1, 1'b0, 1'b1, 4'd3, head(0, 3), 1'b0};
        tbl[5] = '{1'b1, 64'h0,       1'b1, 1'b1, 1'b0, 4'd0, head(0, 0), 1'b1};
        tbl[6] = '{1'b1, 64'h0,       1'b1, 1'b1, 1'b0, 4'd0, head(0, 0), 1'b0};
        for (int i = 0; i < 7; i++) begin
            in_valid_n   = tbl[i].vn;
            group_matrix = tbl[i].gm;
            out_ready    = tbl[i].rdy;
            step();
            chk_all($sformatf("tbl%0d", i), tbl[i].ovn, tbl[i].bsy, tbl[i].idx, tbl[i].hm, tbl[i].dn, 1'b0);
        end

        load(1, 0);
        drain_seq("stall", 7'b1011001, 7'b0000000, 7, 1);

        load(0, 3);
        drain_seq("gap", 7'b0001111, 7'b0000000, 4, 0);

        load(3, 0);
        drain_seq("ovf", 7'b0001111, 7'b0001010, 4, 3);

        load(4, 0);
        out_ready = 1'b1;
        step();
        step();
        chk_all("pre_rst", 1'b0, 1'b1, 4'd2, head(4, 2), 1'b0, ovf);
        #2 rst_n = 1'b0;
        #1;
        ovf = 1'b0;
        chk_all("async_rst", 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        chk_all("rst_hold", 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        load(5, 0);
        drain_seq("fresh", 7'b0001111, 7'b0000000, 4, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/split_head_dispatcher.md
# split_head_dispatcher

Downstream stage of the head-group splitter in the attention op-trans path. It captures the GROUP_NUM consecutive head-group slices the splitter emits while its active-low valid is asserted. It then gathers each individual head out of the interleaved [SEQ_LEN][GROUP_HEADS][HEAD_DIM] slice layout. Heads are presented one per transaction to the per-head attention datapath under a valid/ready handshake.

## Interface
- DATA_WIDTH, 8, element width in bits
- SEQ_LEN, 128, sequence length (slice dim 1)
- GROUP_HEADS, 4, heads per incoming slice (slice dim 2)
- HEAD_DIM, 64, per-head feature width (slice dim 3)
- HEAD_NUM, 12, total heads; must be a multiple of GROUP_HEADS; GROUP_NUM = HEAD_NUM/GROUP_HEADS
- HEAD_IDX_WIDTH, 4, width of head_idx; 2^HEAD_IDX_WIDTH >= HEAD_NUM
- clk_p  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- group_matrix  in  DATA_WIDTH*SEQ_LEN*GROUP_HEADS*HEAD_DIM  one head-group slice; element (s,h,d) at bit offset ((s*GROUP_HEADS+h)*HEAD_DIM+d)*DATA_WIDTH
- in_valid_n  in  1  active-low; group_matrix valid this cycle
- busy  out  1  high in DRAIN; upstream must hold in_valid_n high while set
- head_matrix  out  DATA_WIDTH*SEQ_LEN*HEAD_DIM  current head; element (s,d) at offset (s*HEAD_DIM+d)*DATA_WIDTH
- head_idx  out  HEAD_IDX_WIDTH  global head number of head_matrix (g*GROUP_HEADS+h)
- out_valid_n  out  1  active-low; head_matrix/head_idx valid
- out_ready  in  1  active-high consumer ready
- done  out  1  one-cycle pulse after the last head transfers
- overflow  out  1  sticky; a beat arrived while busy

## Operation
- Buffer: GROUP_NUM slots of slice width, written at index fill_cnt. Storage is cleared to 0 on reset.
- fill_cnt: 0..GROUP_NUM-1. head_cnt: 0..HEAD_NUM-1.
- States: IDLE (buffer empty), FILL (partial), DRAIN (emitting).
- IDLE/FILL, in_valid_n low: write the slot and increment fill_cnt. If this was slot GROUP_NUM-1, go to DRAIN, clear fill_cnt and head_cnt. Otherwise go to (or stay in) FILL.
- With GROUP_NUM==1, IDLE goes directly to DRAIN.
- IDLE/FILL, in_valid_n high: hold state. FILL has no timeout; gaps between beats are allowed.
- DRAIN: slot g = head_cnt / GROUP_HEADS, h = head_cnt % GROUP_HEADS.
  - head_matrix is gathered combinationally from slot g: for every s,d, head element (s,d) = slice element (s,h,d).
  - head_idx = head_cnt.
- Transfer occurs on a clock edge with out_valid_n low and out_ready high; head_cnt increments.
- On the transfer with head_cnt == HEAD_NUM-1: go to IDLE, clear head_cnt, register done=1 for the next cycle.
- Any in_valid_n low while in DRAIN, including the final-transfer cycle, is dropped: no write, overflow←1 until reset.
- head_matrix/head_idx hold stable while out_valid_n low and out_ready low.

## Timing
- Reset values: busy 0, out_valid_n 1, head_idx 0, head_matrix 0, done 0, overflow 0, state IDLE, counters 0.
- Reset mid-FILL or mid-DRAIN: all state and buffer are discarded immediately (asynchronous). Partial groups are lost.
- Fill latency: out_valid_n falls and busy rises in the cycle after the edge capturing the last slice.
- Throughput: one head per cycle with out_ready held high. A full drain takes HEAD_NUM cycles.
- out_valid_n and busy rise in the cycle after the final transfer edge; done is high for that same single cycle.
- The next group may be accepted in that same cycle (state is IDLE).
- out_valid_n and busy are registered from state. head_matrix is combinational from buffer and head_cnt, with no output register.

## Test plan
Bench parameters: DATA_WIDTH 8, SEQ_LEN 2, GROUP_HEADS 2, HEAD_DIM 2, HEAD_NUM 4 (GROUP_NUM 2). Slice element byte = {g[1:0],s,h,d,3'b0}.
- Reset with no stimulus -> all outputs at reset values; head_matrix = 0.
- Two back-to-back beats (g=0,1), out_ready=1 -> out_valid_n low starting the cycle after beat 2, for 4 cycles.
  - head_idx 0,1,2,3.
  - Head 1 = bytes {g0,s0,h1,d0},{g0,s0,h1,d1},{g0,s1,h1,d0},{g0,s1,h1,d1} in element order (s,d).
  - done pulses once.
- Same load with out_ready toggled 1,0,0,1,1,0,1 -> no head skipped or repeated; head_matrix stable during stalls.
- Beats with 3-cycle gap between them -> state stays FILL; identical drain contents.
- in_valid_n low during DRAIN (mid-drain and on the last-transfer cycle) -> overflow=1 and sticky; buffer contents unchanged; drain completes normally.
- rst_n pulsed low mid-drain (after head 1) -> outputs at reset values asynchronously. A fresh 2-beat load then drains heads 0..3 of the new data.
